// File: rtl/seg_display_sched.sv
// Display scheduler: background digits (optionally blinking) preempted by one-shot req/ack messages.
// Latency 1 clk, all outputs registered; backpressure: msg_req is held until the msg_ack pulse, ignored while busy.
module seg_display_sched #(
    parameter int         HOLD_TICKS = 8,
    parameter int         BLINK_DIV  = 4,
    parameter logic [3:0] BLANK_CODE = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [3:0]  bg_d3,
    input  logic [3:0]  bg_d2,
    input  logic [3:0]  bg_d1,
    input  logic [3:0]  bg_d0,
    input  logic        blink_en,
    input  logic        msg_req,
    input  logic [15:0] msg_d,
    output logic        msg_ack,
    output logic        busy,
    output logic [3:0]  cnt3,
    output logic [3:0]  cnt2,
    output logic [3:0]  cnt1,
    output logic [3:0]  cnt0
);

    typedef enum logic [1:0] {
        S_BG,
        S_MSG,
        S_GAP
    } state_t;

    localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_TICKS);
    localparam logic [7:0]  BLINK_TOP = 8'(BLINK_DIV - 1);
    localparam logic [15:0] BLANK4    = {4{BLANK_CODE}};

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        hidden_q, hidden_d;
    logic [15:0] msg_lat_q, msg_lat_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BG;
            timer_q     <= 8'd0;
            blink_cnt_q <= 8'd0;
            hidden_q    <= 1'b0;
            msg_lat_q   <= 16'd0;
            cnt_q       <= BLANK4;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            hidden_q    <= hidden_d;
            msg_lat_q   <= msg_lat_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        blink_cnt_d = blink_cnt_q;
        hidden_d    = hidden_q;
        msg_lat_d   = msg_lat_q;
        ack_d       = 1'b0;

        unique case (state_q)
            S_BG: begin
                // Accept has priority over a coincident tick; that tick is consumed by neither.
                if (msg_req) begin
                    msg_lat_d   = msg_d;
                    timer_d     = HOLD_LOAD;
                    state_d     = S_MSG;
                    ack_d       = 1'b1;
                    blink_cnt_d = 8'd0;
                    hidden_d    = 1'b0;
                end else if (!blink_en) begin
                    blink_cnt_d = 8'd0;
                    hidden_d    = 1'b0;
                end else if (tick) begin
                    if (blink_cnt_q == BLINK_TOP) begin
                        blink_cnt_d = 8'd0;
                        hidden_d    = ~hidden_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
            end
            S_MSG: begin
                if (tick && timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    state_d = S_BG;
                end
            end
            default: state_d = S_BG;
        endcase

        // Outputs follow the next state so every change lands exactly one clk after its cause.
        unique case (state_d)
            S_BG:    cnt_d = hidden_d ? BLANK4 : {bg_d3, bg_d2, bg_d1, bg_d0};
            S_MSG:   cnt_d = msg_lat_d;
            default: cnt_d = BLANK4;
        endcase
        busy_d = (state_d != S_BG);
    end

    assign msg_ack = ack_q;
    assign busy    = busy_q;
    assign cnt3    = cnt_q[15:12];
    assign cnt2    = cnt_q[11:8];
    assign cnt1    = cnt_q[7:4];
    assign cnt0    = cnt_q[3:0];

endmodule
